// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, state encodings and iteration count for the multiply/divide
// unit; also imported by the core's decode logic.
package muldiv_unit_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   localparam int MDU_ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_t;

   // Ops 0-3 occupy the iterative datapath; 4-7 are handled directly in IDLE.
   function automatic logic is_muldiv(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negation: extracts operand magnitudes on the way
// in and restores result signs on the way out.
module muldiv_unit_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   assign result = negate ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO for the EX stage.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply (IDLE -> FIX).
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(MDU_ITERS);

   mdu_state_t           state;
   logic [CW-1:0]        cnt;
   logic                 is_div;
   logic                 neg_res;
   logic                 neg_rem;
   logic                 div_zero;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [2*WIDTH-1:0]   acc;

   logic                 signed_op;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     diff;
   logic                 ge;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH-1:0]     quot_next;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quot;
   logic [WIDTH-1:0]     rem;

   assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);

   muldiv_unit_signfix #(.W(WIDTH)) u_fix_a (
      .value  (a),
      .negate (signed_op & a[WIDTH-1]),
      .result (abs_a)
   );

   muldiv_unit_signfix #(.W(WIDTH)) u_fix_b (
      .value  (b),
      .negate (signed_op & b[WIDTH-1]),
      .result (abs_b)
   );

   // Multiply walks the multiplier MSB-first; divide shifts quotient bits in at
   // the LSB while the partial remainder lives in the upper half of acc.
   assign mul_next  = {acc[2*WIDTH-2:0], 1'b0} + (mag_b[cnt] ? {{WIDTH{1'b0}}, mag_a} : '0);
   assign trial     = {acc[2*WIDTH-1:WIDTH], mag_a[cnt]};
   assign ge        = trial >= {1'b0, mag_b};
   assign diff      = trial[WIDTH-1:0] - mag_b;
   assign rem_next  = ge ? diff : trial[WIDTH-1:0];
   assign quot_next = {acc[WIDTH-2:0], ge};

   muldiv_unit_signfix #(.W(2*WIDTH)) u_fix_prod (
      .value  (acc),
      .negate (neg_res),
      .result (prod)
   );

   muldiv_unit_signfix #(.W(WIDTH)) u_fix_quot (
      .value  (acc[WIDTH-1:0]),
      .negate (neg_res),
      .result (quot)
   );

   muldiv_unit_signfix #(.W(WIDTH)) u_fix_rem (
      .value  (acc[2*WIDTH-1:WIDTH]),
      .negate (neg_rem),
      .result (rem)
   );

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

   // Control, counter, accumulator and HI/LO; HI/LO change only in FIX or on MTHI/MTLO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && is_muldiv(op)) begin
                  mag_a    <= abs_a;
                  mag_b    <= abs_b;
                  is_div   <= op[1];
                  neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem  <= signed_op & a[WIDTH-1];
                  div_zero <= (b == '0);
                  acc      <= '0;
                  cnt      <= CW'(MDU_ITERS - 1);
                  busy     <= 1'b1;
                  state    <= ST_CALC;
`ifdef MDU_FAST_MUL_EN
                  if (!op[1]) begin
                     acc   <= fast_prod;
                     state <= ST_FIX;
                  end
`endif
               end else if (start && op == MDU_MTHI) begin
                  hi <= a;
               end else if (start && op == MDU_MTLO) begin
                  lo <= a;
               end
            end
            ST_CALC: begin
               acc <= is_div ? {rem_next, quot_next} : mul_next;
               if (cnt == '0) begin
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_FIX: begin
               if (is_div) begin
                  lo <= div_zero ? '1 : quot;
                  hi <= rem;
               end else begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: multiply/divide results, latency,
// MTHI/MTLO, ignored issue while busy, and reset abort.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_BUSY = 1;
`else
   localparam int MUL_BUSY = 33;
`endif
   localparam int DIV_BUSY = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int compared   = 0;
   int mismatched = 0;
   int busy_cycles;
   bit timed_out;
   bit both_high;
   bit held;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // Called at a falling edge: issues one op, then follows it until done (bounded).
   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] hi0;
      logic [31:0] lo0;
      hi0 = hi;
      lo0 = lo;
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 3'd7; a = '0; b = '0;
      busy_cycles = 0; timed_out = 1'b1; both_high = 1'b0; held = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (busy && done) both_high = 1'b1;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
         if (hi !== hi0 || lo !== lo0) held = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      compared++;
      if ({busy, done} !== 2'b00 || hi !== 32'h0 || lo !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mthi_mtlo();
      start = 1'b1; op = MDU_MTHI; a = 32'h12345678;
      @(negedge clk);
      start = 1'b0;
      compared++;
      if (hi !== 32'h12345678 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mthi: hi=%h lo=%h busy=%b done=%b, required 12345678 0 0 0", hi, lo, busy, done);
      end
      start = 1'b1; op = MDU_MTLO; a = 32'h9abcdef0;
      @(negedge clk);
      start = 1'b0;
      compared++;
      if (lo !== 32'h9abcdef0 || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required 12345678 9abcdef0 0 0", hi, lo, busy, done);
      end
   endtask

   task automatic test_multu();
      applyStimulus(MDU_MULTU, 32'hffffffff, 32'hffffffff);
      compared++;
      if (timed_out || hi !== 32'hfffffffe || lo !== 32'h00000001) begin
         mismatched++;
         $display("[TB] FAIL multu: timeout=%b hi=%h lo=%h, required fffffffe 00000001", timed_out, hi, lo);
      end
      compared++;
      if (busy_cycles != MUL_BUSY || both_high || !held) begin
         mismatched++;
         $display("[TB] FAIL multu_timing: busy=%0d overlap=%b held=%b, required %0d 0 1", busy_cycles, both_high, held, MUL_BUSY);
      end
   endtask

   task automatic test_mult();
      applyStimulus(MDU_MULT, 32'hfffffffd, 32'd7);
      compared++;
      if (timed_out || hi !== 32'hffffffff || lo !== 32'hffffffeb || busy_cycles != MUL_BUSY) begin
         mismatched++;
         $display("[TB] FAIL mult: hi=%h lo=%h busy=%0d, required ffffffff ffffffeb %0d", hi, lo, busy_cycles, MUL_BUSY);
      end
   endtask

   task automatic test_div();
      applyStimulus(MDU_DIV, 32'hfffffff9, 32'd2);
      compared++;
      if (timed_out || lo !== 32'hfffffffd || hi !== 32'hffffffff) begin
         mismatched++;
         $display("[TB] FAIL div: lo=%h hi=%h, required fffffffd ffffffff", lo, hi);
      end
      compared++;
      if (busy_cycles != DIV_BUSY || both_high || !held) begin
         mismatched++;
         $display("[TB] FAIL div_timing: busy=%0d overlap=%b held=%b, required 33 0 1", busy_cycles, both_high, held);
      end
   endtask

   task automatic test_divu();
      applyStimulus(MDU_DIVU, 32'd100, 32'd7);
      compared++;
      if (timed_out || lo !== 32'd14 || hi !== 32'd2) begin
         mismatched++;
         $display("[TB] FAIL divu: lo=%h hi=%h, required 0000000e 00000002", lo, hi);
      end
   endtask

   task automatic test_div_zero();
      applyStimulus(MDU_DIVU, 32'd100, 32'd0);
      compared++;
      if (timed_out || lo !== 32'hffffffff || hi !== 32'h00000064 || busy_cycles != DIV_BUSY) begin
         mismatched++;
         $display("[TB] FAIL divu_zero: lo=%h hi=%h busy=%0d, required ffffffff 00000064 33", lo, hi, busy_cycles);
      end
      applyStimulus(MDU_DIV, 32'hfffffff9, 32'd0);
      compared++;
      if (timed_out || lo !== 32'hffffffff || hi !== 32'hfffffff9) begin
         mismatched++;
         $display("[TB] FAIL div_zero_neg: lo=%h hi=%h, required ffffffff fffffff9", lo, hi);
      end
   endtask

   task automatic test_div_overflow();
      applyStimulus(MDU_DIV, 32'h80000000, 32'hffffffff);
      compared++;
      if (timed_out || lo !== 32'h80000000 || hi !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL div_overflow: lo=%h hi=%h, required 80000000 00000000", lo, hi);
      end
   endtask

   task automatic test_mtlo_busy();
      start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; op = MDU_MTLO; a = 32'hdeadbeef;
      @(negedge clk);
      start = 1'b0; op = 3'd7; a = '0;
      compared++;
      if (lo !== 32'h80000000 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mtlo_while_busy: lo=%h busy=%b, required 80000000 1", lo, busy);
      end
      timed_out = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      compared++;
      if (timed_out || lo !== 32'd14 || hi !== 32'd2) begin
         mismatched++;
         $display("[TB] FAIL divu_after_mtlo: timeout=%b lo=%h hi=%h, required 0000000e 00000002", timed_out, lo, hi);
      end
   endtask

   task automatic test_noop();
      start = 1'b1; op = 3'd6; a = 32'hffffffff; b = 32'hffffffff;
      @(negedge clk);
      op = 3'd7;
      @(negedge clk);
      start = 1'b0;
      compared++;
      if (hi !== 32'd2 || lo !== 32'd14 || busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL noop: hi=%h lo=%h busy=%b done=%b, required 2 e 0 0", hi, lo, busy, done);
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(MDU_DIVU, 32'd1000, 32'd33);
      compared++;
      if (timed_out || lo !== 32'd30 || hi !== 32'd10) begin
         mismatched++;
         $display("[TB] FAIL b2b_first: lo=%h hi=%h, required 0000001e 0000000a", lo, hi);
      end
      applyStimulus(MDU_MULT, 32'hfffffffd, 32'hfffffff9);
      compared++;
      if (timed_out || hi !== 32'h0 || lo !== 32'd21 || busy_cycles != MUL_BUSY) begin
         mismatched++;
         $display("[TB] FAIL b2b_second: hi=%h lo=%h busy=%0d, required 0 00000015 %0d", hi, lo, busy_cycles, MUL_BUSY);
      end
   endtask

   task automatic test_rst_abort();
      start = 1'b1; op = MDU_MTHI; a = 32'haaaaaaaa;
      @(negedge clk);
      op = MDU_MTLO; a = 32'h55555555;
      @(negedge clk);
      op = MDU_MULT; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      compared++;
      if (busy !== 1'b1 || hi !== 32'haaaaaaaa || lo !== 32'h55555555) begin
         mismatched++;
         $display("[TB] FAIL abort_pre: busy=%b hi=%h lo=%h, required 1 aaaaaaaa 55555555", busy, hi, lo);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL abort: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
      end
      applyStimulus(MDU_MULT, 32'd3, 32'd5);
      compared++;
      if (timed_out || hi !== 32'h0 || lo !== 32'd15 || busy_cycles != MUL_BUSY) begin
         mismatched++;
         $display("[TB] FAIL mult_after_abort: hi=%h lo=%h busy=%0d, required 0 0000000f %0d", hi, lo, busy_cycles, MUL_BUSY);
      end
   endtask

   task automatic test_rst_start();
      rst = 1'b1; start = 1'b1; op = MDU_MTHI; a = 32'h00001234;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      compared++;
      if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_over_start: hi=%h lo=%h busy=%b, required 0 0 0", hi, lo, busy);
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_multu();
      test_mult();
      test_div();
      test_divu();
      test_div_zero();
      test_div_overflow();
      test_mtlo_busy();
      test_noop();
      test_back_to_back();
      test_rst_abort();
      test_rst_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
